stream_demux: RTL and testbench

Splits the merged frame stream produced by the stream mux back into three streams:
- a packet stream;
- a metadata stream;
- a user-data stream.

Each merged frame starts with a header flit carrying metadata and two byte lengths, followed by packet flits, then user flits. The block sits directly downstream of the stream mux, on the consumer side of the service link. It registers every output and detects and recovers from framing errors.

---
 rtl/stream_demux.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_stream_demux.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Splits the merged frame stream from the stream mux into three streams:
// packet, metadata and user data. A frame is one header flit (metadata plus
// packet/user byte lengths), then the packet flits, then the user flits.
// Each output is a one-entry registered slot. Framing errors are detected,
// reported with a one-cycle pulse plus a saturating count, and recovered from.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_data/valid/sop/eop/empty   merged input stream
//   in_ready                      input backpressure (combinational)
//   out_pkt_*                     packet stream (data, valid, sop, eop, empty)
//   out_pkt_ready                 packet sink ready
//   out_meta_data/valid           metadata stream
//   out_meta_ready                metadata sink ready
//   out_usr_*                     user stream (data, valid, sop, eop, empty)
//   out_usr_ready                 user sink ready
//   err_frame                     one-cycle pulse per framing error
//   err_cnt                       saturating framing-error count
//
// DATA_W must be 512 and EMPTY_W 6 (64-byte flits); META_W must be <= 480 so
// the metadata does not overlap the length fields at the top of the header.
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int META_W  = 256
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               in_ready,

    output logic [DATA_W-1:0]  out_pkt_data,
    output logic               out_pkt_valid,
    output logic               out_pkt_sop,
    output logic               out_pkt_eop,
    output logic [EMPTY_W-1:0] out_pkt_empty,
    input  logic               out_pkt_ready,

    output logic [META_W-1:0]  out_meta_data,
    output logic               out_meta_valid,
    input  logic               out_meta_ready,

    output logic [DATA_W-1:0]  out_usr_data,
    output logic               out_usr_valid,
    output logic               out_usr_sop,
    output logic               out_usr_eop,
    output logic [EMPTY_W-1:0] out_usr_empty,
    input  logic               out_usr_ready,

    output logic               err_frame,
    output logic [31:0]        err_cnt
);

    localparam int CNT_W = 11;  // flit count up to 1024

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PKT  = 2'd1,
        S_USR  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Per-frame section bookkeeping
    logic [CNT_W-1:0]   r_pkt_cnt,  w_pkt_cnt_next;
    logic [CNT_W-1:0]   r_usr_cnt,  w_usr_cnt_next;
    logic [EMPTY_W-1:0] r_pkt_emp,  w_pkt_emp_next;
    logic [EMPTY_W-1:0] r_usr_emp,  w_usr_emp_next;
    logic               r_first,    w_first_next;   // next section flit is its first

    logic               r_err_frame;
    logic [31:0]        r_err_cnt;
    logic               w_err;

    // Metadata output slot
    logic               r_meta_valid;
    logic [META_W-1:0]  r_meta_data;
    logic               w_meta_ld;

    // Streaming output slots: index 0 = packet, 1 = user
    logic [1:0]         w_ld;
    logic               w_eop;
    logic [EMPTY_W-1:0] w_empty;
    logic [1:0]         w_str_ready;
    logic [1:0]         w_str_valid;
    logic [1:0]         w_str_sop;
    logic [1:0]         w_str_eop;
    logic [DATA_W-1:0]  w_str_data  [2];
    logic [EMPTY_W-1:0] w_str_empty [2];

    // ---------------------------------------------------------------------
    // Header decode (only meaningful when the current flit is a header)
    // ---------------------------------------------------------------------
    logic [15:0]        w_pkt_len, w_usr_len;
    logic [16:0]        w_pkt_sum, w_usr_sum;
    logic [CNT_W-1:0]   w_pkt_flits, w_usr_flits;
    logic [EMPTY_W-1:0] w_pkt_last_emp, w_usr_last_emp;
    logic               w_lens_zero;
    logic               w_hdr_ok;

    assign w_pkt_len   = in_data[511:496];
    assign w_usr_len   = in_data[495:480];
    // ceil(len/64) without a divider: add 63, drop the low six bits
    assign w_pkt_sum   = {1'b0, w_pkt_len} + 17'd63;
    assign w_usr_sum   = {1'b0, w_usr_len} + 17'd63;
    assign w_pkt_flits = w_pkt_sum[16:6];
    assign w_usr_flits = w_usr_sum[16:6];
    // (64 - len[5:0]) mod 64; a multiple of 64 wraps to 0
    assign w_pkt_last_emp = EMPTY_W'(7'd64 - {1'b0, w_pkt_len[5:0]});
    assign w_usr_last_emp = EMPTY_W'(7'd64 - {1'b0, w_usr_len[5:0]});
    assign w_lens_zero = (w_pkt_len == 16'd0) && (w_usr_len == 16'd0);
    assign w_hdr_ok    = in_sop && (in_eop == w_lens_zero);

    // ---------------------------------------------------------------------
    // Section position
    // ---------------------------------------------------------------------
    logic               w_in_usr;
    logic [CNT_W-1:0]   w_cnt;
    logic [EMPTY_W-1:0] w_sec_emp;
    logic               w_sec_last;
    logic               w_frame_last;

    assign w_in_usr     = (r_state == S_USR);
    assign w_cnt        = w_in_usr ? r_usr_cnt : r_pkt_cnt;
    assign w_sec_emp    = w_in_usr ? r_usr_emp : r_pkt_emp;
    assign w_sec_last   = (w_cnt == CNT_W'(1));
    // The packet section's last flit also ends the frame when there is no user data
    assign w_frame_last = w_sec_last && (w_in_usr || (r_usr_cnt == '0));

    // ---------------------------------------------------------------------
    // Input handshake: ready follows the output slot the state feeds
    // ---------------------------------------------------------------------
    logic w_sel_valid, w_sel_ready, w_accept;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_ready = 1'b1;
        case (r_state)
            S_HDR: begin
                w_sel_valid = r_meta_valid;
                w_sel_ready = out_meta_ready;
            end
            S_PKT: begin
                w_sel_valid = w_str_valid[0];
                w_sel_ready = out_pkt_ready;
            end
            S_USR: begin
                w_sel_valid = w_str_valid[1];
                w_sel_ready = out_usr_ready;
            end
            default: begin
                w_sel_valid = 1'b0;
                w_sel_ready = 1'b1;
            end
        endcase
    end

    assign in_ready = ~w_sel_valid | w_sel_ready;
    assign w_accept = in_valid & in_ready;

    // ---------------------------------------------------------------------
    // Next-state and load control
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_pkt_cnt_next = r_pkt_cnt;
        w_usr_cnt_next = r_usr_cnt;
        w_pkt_emp_next = r_pkt_emp;
        w_usr_emp_next = r_usr_emp;
        w_first_next   = r_first;
        w_err          = 1'b0;
        w_meta_ld      = 1'b0;
        w_ld           = 2'b00;
        w_eop          = 1'b0;
        w_empty        = '0;

        case (r_state)
            S_HDR: begin
                if (w_accept) begin
                    if (w_hdr_ok) begin
                        w_meta_ld      = 1'b1;
                        w_pkt_cnt_next = w_pkt_flits;
                        w_usr_cnt_next = w_usr_flits;
                        w_pkt_emp_next = w_pkt_last_emp;
                        w_usr_emp_next = w_usr_last_emp;
                        w_first_next   = 1'b1;
                        if (w_pkt_flits != '0) begin
                            w_state_next = S_PKT;
                        end else if (w_usr_flits != '0) begin
                            w_state_next = S_USR;
                        end else begin
                            w_state_next = S_HDR;
                        end
                    end else begin
                        w_err = 1'b1;
                        // A bad header that carries eop is a complete (empty) frame
                        w_state_next = in_eop ? S_HDR : S_DROP;
                    end
                end
            end

            S_PKT, S_USR: begin
                if (w_accept) begin
                    if (w_in_usr) begin
                        w_ld[1]        = 1'b1;
                        w_usr_cnt_next = r_usr_cnt - CNT_W'(1);
                    end else begin
                        w_ld[0]        = 1'b1;
                        w_pkt_cnt_next = r_pkt_cnt - CNT_W'(1);
                    end
                    w_first_next = 1'b0;

                    if (in_sop) begin
                        // A new frame starting mid-frame: close this one, skip the rest
                        w_err        = 1'b1;
                        w_eop        = 1'b1;
                        w_empty      = w_sec_last ? w_sec_emp : '0;
                        w_state_next = S_DROP;
                    end else if (in_eop && !w_frame_last) begin
                        // Truncated frame: the sender's empty is the best we have
                        w_err        = 1'b1;
                        w_eop        = 1'b1;
                        w_empty      = in_empty;
                        w_state_next = S_HDR;
                    end else if (w_frame_last && !in_eop) begin
                        // Over-long frame: close it here and drop the remainder
                        w_err        = 1'b1;
                        w_eop        = 1'b1;
                        w_empty      = w_sec_emp;
                        w_state_next = S_DROP;
                    end else if (w_sec_last) begin
                        w_eop   = 1'b1;
                        w_empty = w_sec_emp;
                        if (!w_in_usr && (r_usr_cnt != '0)) begin
                            w_state_next = S_USR;
                            w_first_next = 1'b1;
                        end else begin
                            w_state_next = S_HDR;
                        end
                    end
                end
            end

            default: begin
                if (w_accept && in_eop) begin
                    w_state_next = S_HDR;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, counters, error reporting
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HDR;
            r_pkt_cnt   <= '0;
            r_usr_cnt   <= '0;
            r_pkt_emp   <= '0;
            r_usr_emp   <= '0;
            r_first     <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pkt_cnt   <= w_pkt_cnt_next;
            r_usr_cnt   <= w_usr_cnt_next;
            r_pkt_emp   <= w_pkt_emp_next;
            r_usr_emp   <= w_usr_emp_next;
            r_first     <= w_first_next;
            r_err_frame <= w_err;
            if (w_err && (r_err_cnt != 32'hFFFF_FFFF)) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assign err_frame = r_err_frame;
    assign err_cnt   = r_err_cnt;

    // ---------------------------------------------------------------------
    // Metadata output slot
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_valid <= 1'b0;
            r_meta_data  <= '0;
        end else if (w_meta_ld) begin
            r_meta_valid <= 1'b1;
            r_meta_data  <= in_data[META_W-1:0];
        end else if (out_meta_ready) begin
            r_meta_valid <= 1'b0;
        end
    end

    assign out_meta_valid = r_meta_valid;
    assign out_meta_data  = r_meta_data;

    // ---------------------------------------------------------------------
    // Packet and user output slots (identical structure)
    // ---------------------------------------------------------------------
    assign w_str_ready = {out_usr_ready, out_pkt_ready};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_str
            logic               r_valid;
            logic               r_sop;
            logic               r_eop;
            logic [DATA_W-1:0]  r_data;
            logic [EMPTY_W-1:0] r_empty;

            // Loading takes priority over draining so a slot can refill in
            // the same cycle its current flit is taken.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_sop   <= 1'b0;
                    r_eop   <= 1'b0;
                    r_data  <= '0;
                    r_empty <= '0;
                end else if (w_ld[gi]) begin
                    r_valid <= 1'b1;
                    r_sop   <= r_first;
                    r_eop   <= w_eop;
                    r_data  <= in_data;
                    r_empty <= w_empty;
                end else if (w_str_ready[gi]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_str_valid[gi] = r_valid;
            assign w_str_sop[gi]   = r_sop;
            assign w_str_eop[gi]   = r_eop;
            assign w_str_data[gi]  = r_data;
            assign w_str_empty[gi] = r_empty;
        end
    endgenerate

    assign out_pkt_valid = w_str_valid[0];
    assign out_pkt_sop   = w_str_sop[0];
    assign out_pkt_eop   = w_str_eop[0];
    assign out_pkt_data  = w_str_data[0];
    assign out_pkt_empty = w_str_empty[0];

    assign out_usr_valid = w_str_valid[1];
    assign out_usr_sop   = w_str_sop[1];
    assign out_usr_eop   = w_str_eop[1];
    assign out_usr_data  = w_str_data[1];
    assign out_usr_empty = w_str_empty[1];

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Directed bench for stream_demux. Expected flits and metadata are queued when
// stimulus is driven and compared when each output handshakes.
// -----------------------------------------------------------------------------
module tb_stream_demux;

    localparam int DATA_W  = 512;
    localparam int EMPTY_W = 6;
    localparam int META_W  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_sop;
    logic               in_eop;
    logic [EMPTY_W-1:0] in_empty;
    logic               in_ready;
    logic [DATA_W-1:0]  out_pkt_data;
    logic               out_pkt_valid;
    logic               out_pkt_sop;
    logic               out_pkt_eop;
    logic [EMPTY_W-1:0] out_pkt_empty;
    logic               out_pkt_ready;
    logic [META_W-1:0]  out_meta_data;
    logic               out_meta_valid;
    logic               out_meta_ready;
    logic [DATA_W-1:0]  out_usr_data;
    logic               out_usr_valid;
    logic               out_usr_sop;
    logic               out_usr_eop;
    logic [EMPTY_W-1:0] out_usr_empty;
    logic               out_usr_ready;
    logic               err_frame;
    logic [31:0]        err_cnt;

    stream_demux #(
        .DATA_W  (DATA_W),
        .EMPTY_W (EMPTY_W),
        .META_W  (META_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_empty       (in_empty),
        .in_ready       (in_ready),
        .out_pkt_data   (out_pkt_data),
        .out_pkt_valid  (out_pkt_valid),
        .out_pkt_sop    (out_pkt_sop),
        .out_pkt_eop    (out_pkt_eop),
        .out_pkt_empty  (out_pkt_empty),
        .out_pkt_ready  (out_pkt_ready),
        .out_meta_data  (out_meta_data),
        .out_meta_valid (out_meta_valid),
        .out_meta_ready (out_meta_ready),
        .out_usr_data   (out_usr_data),
        .out_usr_valid  (out_usr_valid),
        .out_usr_sop    (out_usr_sop),
        .out_usr_eop    (out_usr_eop),
        .out_usr_empty  (out_usr_empty),
        .out_usr_ready  (out_usr_ready),
        .err_frame      (err_frame),
        .err_cnt        (err_cnt)
    );

    typedef struct packed {
        logic [DATA_W-1:0]  d;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] emp;
    } flit_t;

    flit_t             q_pkt[$];
    flit_t             q_usr[$];
    logic [META_W-1:0] q_meta[$];

    int checks       = 0;
    int errors       = 0;
    int err_seen     = 0;
    int stall_cycles = 0;

    task automatic check(input string tag, input logic [519:0] obs, input logic [519:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_hdr(input logic [META_W-1:0] m,
                                                 input logic [15:0] pl,
                                                 input logic [15:0] ul);
        logic [DATA_W-1:0] h;
        h = '0;
        h[META_W-1:0] = m;
        h[511:496]    = pl;
        h[495:480]    = ul;
        return h;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [META_W-1:0] rnd_meta();
        logic [META_W-1:0] r;
        for (int i = 0; i < META_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- output monitors (sampled on the falling edge) -------
    always @(negedge clk) begin
        flit_t e;
        if (out_pkt_valid === 1'b1 && out_pkt_ready === 1'b1) begin
            if (q_pkt.size() == 0) begin
                check("pkt_unexpected", 520'(1), 520'(0));
            end else begin
                e = q_pkt.pop_front();
                $display("[%0t] pkt  sop=%0b eop=%0b empty=%0d", $time, out_pkt_sop, out_pkt_eop, out_pkt_empty);
                check("pkt_flit", {out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty}, e);
            end
        end
    end

    always @(negedge clk) begin
        flit_t e;
        if (out_usr_valid === 1'b1 && out_usr_ready === 1'b1) begin
            if (q_usr.size() == 0) begin
                check("usr_unexpected", 520'(1), 520'(0));
            end else begin
                e = q_usr.pop_front();
                $display("[%0t] usr  sop=%0b eop=%0b empty=%0d", $time, out_usr_sop, out_usr_eop, out_usr_empty);
                check("usr_flit", {out_usr_data, out_usr_sop, out_usr_eop, out_usr_empty}, e);
            end
        end
    end

    always @(negedge clk) begin
        logic [META_W-1:0] m;
        if (out_meta_valid === 1'b1 && out_meta_ready === 1'b1) begin
            if (q_meta.size() == 0) begin
                check("meta_unexpected", 520'(1), 520'(0));
            end else begin
                m = q_meta.pop_front();
                $display("[%0t] meta %0h", $time, out_meta_data[31:0]);
                check("meta", 520'(out_meta_data), 520'(m));
            end
        end
    end

    always @(negedge clk) begin
        if (err_frame === 1'b1) begin
            err_seen++;
            $display("[%0t] err_frame pulse, err_cnt=%0d", $time, err_cnt);
        end
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic send(input logic [DATA_W-1:0] d, input logic sop, input logic eop,
                        input logic [EMPTY_W-1:0] emp);
        int n;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = emp;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            stall_cycles++;
            n++;
            if (n >= 100) begin
                check("in_ready_timeout", 520'(0), 520'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_flit(input bit usr, input logic [DATA_W-1:0] d, input logic sop,
                             input logic eop, input logic [EMPTY_W-1:0] emp);
        flit_t e;
        e.d = d; e.sop = sop; e.eop = eop; e.emp = emp;
        if (usr) q_usr.push_back(e);
        else     q_pkt.push_back(e);
    endtask

    // Well-formed frame; expectations derived from the byte lengths.
    task automatic run_frame(input int pl, input int ul);
        int pf, uf;
        logic [META_W-1:0] m;
        logic [DATA_W-1:0] d;
        bit last;
        pf = (pl + 63) / 64;
        uf = (ul + 63) / 64;
        m  = rnd_meta();
        q_meta.push_back(m);
        send(mk_hdr(m, 16'(pl), 16'(ul)), 1'b1, (pf == 0 && uf == 0), '0);
        for (int i = 0; i < pf; i++) begin
            d = rnd_data();
            last = (i == pf - 1);
            push_flit(1'b0, d, (i == 0), last, last ? EMPTY_W'((64 - pl % 64) % 64) : '0);
            send(d, 1'b0, last && (uf == 0), '0);
        end
        for (int i = 0; i < uf; i++) begin
            d = rnd_data();
            last = (i == uf - 1);
            push_flit(1'b1, d, (i == 0), last, last ? EMPTY_W'((64 - ul % 64) % 64) : '0);
            send(d, 1'b0, last, '0);
        end
    endtask

    // ---------------- directed sequence ----------------------------------
    initial begin
        logic [META_W-1:0] m;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] d_hold;
        int s;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
        out_pkt_ready = 1'b1; out_meta_ready = 1'b1; out_usr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valids", 520'({out_pkt_valid, out_meta_valid, out_usr_valid, err_frame}), 520'(0));
        check("rst_in_ready", 520'(in_ready), 520'(1));
        check("rst_err_cnt", 520'(err_cnt), 520'(0));
        @(posedge clk); #1;

        // 1: packet-only frame, 100 bytes -> 2 flits, last empty 28
        run_frame(100, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_err_cnt", 520'(err_cnt), 520'(0));
        check("t1_pkt_empty_q", 520'(q_pkt.size()), 520'(0));

        // 2: 64 B packet + 130 B user, all sinks ready, no backpressure
        s = stall_cycles;
        run_frame(64, 130);
        check("t2_no_stall", 520'(stall_cycles), 520'(s));

        // 3: header-only frame, then a new frame right behind it
        run_frame(0, 0);
        run_frame(64, 0);

        // 4: pkt_len=200 (4 flits) but eop on flit 2 with in_empty=5
        m = rnd_meta();
        q_meta.push_back(m);
        send(mk_hdr(m, 16'd200, 16'd0), 1'b1, 1'b0, '0);
        d = rnd_data(); push_flit(1'b0, d, 1'b1, 1'b0, '0);    send(d, 1'b0, 1'b0, '0);
        d = rnd_data(); push_flit(1'b0, d, 1'b0, 1'b1, 6'd5);  send(d, 1'b0, 1'b1, 6'd5);
        repeat (3) @(posedge clk);
        #1;
        check("t4_err_pulses", 520'(err_seen), 520'(1));
        check("t4_err_cnt", 520'(err_cnt), 520'(1));
        run_frame(128, 64);

        // 5: packet sink stalls 5 cycles mid-packet (256 B -> 4 flits)
        out_pkt_ready = 1'b0;
        m = rnd_meta();
        q_meta.push_back(m);
        send(mk_hdr(m, 16'd256, 16'd0), 1'b1, 1'b0, '0);
        d_hold = rnd_data(); push_flit(1'b0, d_hold, 1'b1, 1'b0, '0); send(d_hold, 1'b0, 1'b0, '0);
        d = rnd_data();
        in_data = d; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_in_ready_low", 520'(in_ready), 520'(0));
            check("t5_pkt_hold", 520'({out_pkt_valid, out_pkt_data}), 520'({1'b1, d_hold}));
        end
        @(posedge clk); #1;
        out_pkt_ready = 1'b1;
        push_flit(1'b0, d, 1'b0, 1'b0, '0); send(d, 1'b0, 1'b0, '0);
        d = rnd_data(); push_flit(1'b0, d, 1'b0, 1'b0, '0); send(d, 1'b0, 1'b0, '0);
        d = rnd_data(); push_flit(1'b0, d, 1'b0, 1'b1, '0); send(d, 1'b0, 1'b1, '0);

        // 6: reset in the middle of the user section
        m = rnd_meta();
        q_meta.push_back(m);
        send(mk_hdr(m, 16'd64, 16'd192), 1'b1, 1'b0, '0);
        d = rnd_data(); push_flit(1'b0, d, 1'b1, 1'b1, '0); send(d, 1'b0, 1'b0, '0);
        d = rnd_data(); push_flit(1'b1, d, 1'b1, 1'b0, '0); send(d, 1'b0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6_valids", 520'({out_pkt_valid, out_meta_valid, out_usr_valid, err_frame}), 520'(0));
        check("t6_err_cnt", 520'(err_cnt), 520'(0));
        check("t6_in_ready", 520'(in_ready), 520'(1));
        run_frame(100, 130);

        repeat (5) @(posedge clk);
        #1;
        check("end_pkt_q", 520'(q_pkt.size()), 520'(0));
        check("end_usr_q", 520'(q_usr.size()), 520'(0));
        check("end_meta_q", 520'(q_meta.size()), 520'(0));
        check("end_err_pulses", 520'(err_seen), 520'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
